equiv_sweeper: RTL and testbench
================================

EQUIV_SWEEPER -- requirements
Module: equiv_sweeper

Interface
REQ-001 Parameter N_IN, default 2: width of the applied input vector x; sweep covers 2^N_IN vectors; legal range 1..16.
REQ-002 Parameter W_OUT, default 2: width of each compared output bus s1, s2.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 start  input  1  sweep request; sampled on rising clk.
REQ-006 stop_on_err  input  1  mode select; captured on accepted start; 1 = halt at first mismatch.
REQ-007 s1  input  W_OUT  output of function A for current x.
REQ-008 s2  input  W_OUT  output of function B for current x.
REQ-009 x  output  N_IN  registered vector applied to both functions.
REQ-010 busy  output  1  high while state is SWEEP.
REQ-011 done  output  1  high while state is DONE.
REQ-012 equal  output  1  valid when done; 1 = no mismatch seen.
REQ-013 err_count  output  N_IN+1  number of mismatching vectors; saturation not needed, width holds 2^N_IN.
REQ-014 first_bad  output  N_IN  first mismatching vector.
REQ-015 first_bad_valid  output  1  high once a mismatch has been recorded.

Function
REQ-016 FSM states IDLE, SWEEP, DONE.
REQ-017 IDLE: x=0, busy=0, done=0; start=1 -> SWEEP, x=0, err_count=0, first_bad=0, first_bad_valid=0, mode latched.
REQ-018 SWEEP: s1 and s2 are combinational functions of x; each rising edge compares s1 vs s2 (all W_OUT bits) for the current x, then increments x.
REQ-019 Mismatch (s1 != s2) on a compare edge: err_count+1; if first_bad_valid=0, first_bad=x and first_bad_valid=1 on the same edge.
REQ-020 Compare edge with x = 2^N_IN-1: -> DONE; x wraps to 0; no further compares.
REQ-021 stop_on_err=1 and mismatch: -> DONE on that edge; x returns to 0; err_count=1.
REQ-022 Latency: stop_on_err=0 -> done rises exactly 2^N_IN cycles after the accepting start edge.
REQ-023 DONE: equal = (err_count==0); err_count, first_bad, first_bad_valid held.
REQ-024 start in DONE -> SWEEP with the same clears as REQ-017.
REQ-025 start while busy is ignored; sweep continues unchanged.
REQ-026 start held high continuously: one sweep per DONE visit; DONE lasts one cycle, then a new sweep begins.
REQ-027 equal=0 whenever done=0.

Reset
REQ-028 rst=1 forces IDLE immediately without a clock edge, including during a sweep.
REQ-029 Reset values: x=0, busy=0, done=0, equal=0, err_count=0, first_bad=0, first_bad_valid=0, latched mode=0.
REQ-030 First start is accepted on the first rising clk after rst falls.

Structure
REQ-031 Shared package eq_sweep_pkg holds the state encoding (IDLE=2'd0, SWEEP=2'd1, DONE=2'd2) and the state width constant.
REQ-032 One sub-module, sweep_counter (N_IN-bit counter with clear, enable and terminal-count flag), generates x.
REQ-033 Comparison, error counter and first_bad capture live in equiv_sweeper.

Verification
REQ-034 N_IN=2, W_OUT=1, s1=s2=x[1]|x[0]; pulse start -> done after 4 cycles, equal=1, err_count=0, first_bad_valid=0.
REQ-035 N_IN=2, s1=x[1]&x[0], s2=x[1] -> err_count=1, first_bad=2, equal=0 (mismatch only at x=2).
REQ-036 stop_on_err=1, s2=~s1 -> done 1 cycle after start, err_count=1, first_bad=0, x=0.
REQ-037 N_IN=4, s2=~s1 always -> err_count=16 (5-bit), first_bad=0, done after 16 cycles.
REQ-038 Assert rst mid-sweep at x=2, between clock edges -> all outputs at reset values before the next edge; state IDLE.
REQ-039 start pulsed at x=1 during a sweep -> ignored; start in DONE -> new sweep, counters cleared.

Source files
------------

// File: rtl/eq_sweep_pkg.sv
// eq_sweep_pkg: shared state encoding for the equivalence sweeper
package eq_sweep_pkg;
  localparam int STATE_W = 2;
  localparam logic [STATE_W-1:0] IDLE  = 2'd0;
  localparam logic [STATE_W-1:0] SWEEP = 2'd1;
  localparam logic [STATE_W-1:0] DONE  = 2'd2;
endpackage

// File: rtl/sweep_counter.sv
// sweep_counter: N-bit vector counter with clear, enable and terminal-count flag
module sweep_counter #(
  parameter int N = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [N-1:0] count,
  output logic         tc
);
  assign tc = &count;
  always_ff @(posedge clk or posedge rst)
    if (rst) count <= '0;
    else if (clr) count <= '0;
    else if (en) count <= count + 1'b1;
endmodule

// File: rtl/equiv_sweeper.sv
// equiv_sweeper: applies every N_IN-bit vector to two functions and compares their outputs
module equiv_sweeper
  import eq_sweep_pkg::*;
#(
  parameter int N_IN  = 2,
  parameter int W_OUT = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            stop_on_err,
  input  logic [W_OUT-1:0] s1,
  input  logic [W_OUT-1:0] s2,
  output logic [N_IN-1:0] x,
  output logic            busy,
  output logic            done,
  output logic            equal,
  output logic [N_IN:0]   err_count,
  output logic [N_IN-1:0] first_bad,
  output logic            first_bad_valid
);
  logic [STATE_W-1:0] state;
  logic mode, tc, go, cmp, bad, halt, last;
  assign busy  = state == SWEEP;
  assign done  = state == DONE;
  assign equal = done && err_count == '0;
  // start is only honoured outside a sweep; a halt or the final vector ends it
  assign go   = start && !busy;
  assign cmp  = busy;
  assign bad  = cmp && s1 != s2;
  assign halt = bad && mode;
  assign last = cmp && (tc || halt);
  sweep_counter #(.N(N_IN)) u_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (go || halt),
    .en   (cmp),
    .count(x),
    .tc   (tc)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state           <= IDLE;
      mode            <= 1'b0;
      err_count       <= '0;
      first_bad       <= '0;
      first_bad_valid <= 1'b0;
    end else if (go) begin
      state           <= SWEEP;
      mode            <= stop_on_err;
      err_count       <= '0;
      first_bad       <= '0;
      first_bad_valid <= 1'b0;
    end else begin
      if (last) state <= DONE;
      if (bad) err_count <= err_count + 1'b1;
      if (bad && !first_bad_valid) begin
        first_bad       <= x;
        first_bad_valid <= 1'b1;
      end
    end
endmodule

// File: tb/tb_equiv_sweeper.sv
// tb_equiv_sweeper: directed checks of the sweeper at N_IN=2 and N_IN=4
module tb_equiv_sweeper;
  logic clk = 1'b0;
  logic rst, start, stop_on_err, start4;
  int sel;
  logic [0:0] s1, s2, s1_4, s2_4;
  logic [1:0] x;
  logic [3:0] x4;
  logic busy, done, equal, fbv, busy4, done4, equal4, fbv4;
  logic [2:0] err;
  logic [4:0] err4;
  logic [1:0] fb;
  logic [3:0] fb4;
  int vectors = 0;
  int errs = 0;
  always #5 clk = ~clk;
  assign s1   = sel == 1 ? x[1] & x[0] : sel == 2 ? x[0] : x[1] | x[0];
  assign s2   = sel == 1 ? x[1] : sel == 2 ? ~x[0] : x[1] | x[0];
  assign s1_4 = x4[0];
  assign s2_4 = ~x4[0];
  equiv_sweeper #(.N_IN(2), .W_OUT(1)) dut (
    .clk(clk), .rst(rst), .start(start), .stop_on_err(stop_on_err),
    .s1(s1), .s2(s2), .x(x), .busy(busy), .done(done), .equal(equal),
    .err_count(err), .first_bad(fb), .first_bad_valid(fbv)
  );
  equiv_sweeper #(.N_IN(4), .W_OUT(1)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .stop_on_err(1'b0),
    .s1(s1_4), .s2(s2_4), .x(x4), .busy(busy4), .done(done4), .equal(equal4),
    .err_count(err4), .first_bad(fb4), .first_bad_valid(fbv4)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic chk_idle(input string tag);
    chk({tag, "_x"}, 32'(x), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_equal"}, 32'(equal), 0);
    chk({tag, "_err"}, 32'(err), 0);
    chk({tag, "_fb"}, 32'(fb), 0);
    chk({tag, "_fbv"}, 32'(fbv), 0);
  endtask
  initial begin
    rst = 1'b1; start = 1'b0; start4 = 1'b0; stop_on_err = 1'b0; sel = 0;
    step(2);
    chk_idle("reset");
    rst = 1'b0;
    // equivalent functions: four compares, no errors
    start = 1'b1; step(1); start = 1'b0;
    chk("t1_busy", 32'(busy), 1);
    chk("t1_x0", 32'(x), 0);
    step(3);
    chk("t1_not_done", 32'(done), 0);
    step(1);
    chk("t1_done", 32'(done), 1);
    chk("t1_equal", 32'(equal), 1);
    chk("t1_err", 32'(err), 0);
    chk("t1_fbv", 32'(fbv), 0);
    chk("t1_busy_off", 32'(busy), 0);
    // single mismatch at x=2
    sel = 1;
    start = 1'b1; step(1); start = 1'b0;
    step(4);
    chk("t2_done", 32'(done), 1);
    chk("t2_err", 32'(err), 1);
    chk("t2_fb", 32'(fb), 2);
    chk("t2_fbv", 32'(fbv), 1);
    chk("t2_equal", 32'(equal), 0);
    // restart from DONE in stop mode; mode must be latched, not live
    sel = 2; stop_on_err = 1'b1;
    start = 1'b1; step(1); start = 1'b0; stop_on_err = 1'b0;
    chk("t3_busy", 32'(busy), 1);
    chk("t3_err_clr", 32'(err), 0);
    chk("t3_fbv_clr", 32'(fbv), 0);
    step(1);
    chk("t3_done", 32'(done), 1);
    chk("t3_err", 32'(err), 1);
    chk("t3_fb", 32'(fb), 0);
    chk("t3_x", 32'(x), 0);
    chk("t3_equal", 32'(equal), 0);
    // start during a sweep is ignored
    sel = 0;
    start = 1'b1; step(1); start = 1'b0;
    step(1);
    chk("t4_x1", 32'(x), 1);
    start = 1'b1; step(1); start = 1'b0;
    chk("t4_ignored_x", 32'(x), 2);
    chk("t4_ignored_busy", 32'(busy), 1);
    step(2);
    chk("t4_done", 32'(done), 1);
    chk("t4_equal", 32'(equal), 1);
    // asynchronous reset mid-sweep
    sel = 2;
    start = 1'b1; step(1); start = 1'b0;
    step(2);
    chk("t5_x2", 32'(x), 2);
    chk("t5_err2", 32'(err), 2);
    rst = 1'b1; #1;
    chk_idle("t5_rst");
    #2; rst = 1'b0;
    step(1);
    chk("t5_stay_idle", 32'(busy), 0);
    // continuous start: DONE lasts one cycle then a new sweep begins
    sel = 0; start = 1'b1;
    step(1);
    chk("t6_busy", 32'(busy), 1);
    step(4);
    chk("t6_done", 32'(done), 1);
    step(1);
    chk("t6_rebusy", 32'(busy), 1);
    chk("t6_redone", 32'(done), 0);
    chk("t6_eq_low", 32'(equal), 0);
    start = 1'b0;
    // N_IN=4, always mismatching
    start4 = 1'b1; step(1); start4 = 1'b0;
    step(15);
    chk("t7_not_done", 32'(done4), 0);
    step(1);
    chk("t7_done", 32'(done4), 1);
    chk("t7_err", 32'(err4), 16);
    chk("t7_fb", 32'(fb4), 0);
    chk("t7_fbv", 32'(fbv4), 1);
    chk("t7_equal", 32'(equal4), 0);
    chk("t7_x", 32'(x4), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
